// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter between the core LSU and DMA.
package dram_arb_pkg;

    localparam int DEF_STARVE_MAX = 8;
    localparam int DEF_BURST_MAX  = 16;
    localparam int REQ_AW         = 32;

    typedef enum logic {
        ARB,
        BURST
    } state_t;

    typedef struct packed {
        logic              we;
        logic [3:0]        be;
        logic [REQ_AW-1:0] addr;
        logic [31:0]       wdat;
        logic              last;
    } req_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Core, DMA and RAM-side signals of the data-RAM arbiter; master = requesters/RAM, slave = arbiter.
interface dram_arbiter_if #(
    parameter int AW = 32
);
    logic          c_req;
    logic          c_we;
    logic [3:0]    c_be;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdat;
    logic          c_gnt;
    logic          c_rvalid;
    logic [31:0]   c_rdata;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdat;
    logic          d_last;
    logic          d_gnt;
    logic          d_rvalid;
    logic [31:0]   d_rdata;

    logic          dram_we;
    logic [3:0]    dram_we_byte;
    logic          dram_rd;
    logic [AW-1:0] dram_addr;
    logic [31:0]   dram_wdat;
    logic [31:0]   dram_dout;

    modport master (
        output c_req, c_we, c_be, c_addr, c_wdat,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_be, d_addr, d_wdat, d_last,
        input  d_gnt, d_rvalid, d_rdata,
        input  dram_we, dram_we_byte, dram_rd, dram_addr, dram_wdat,
        output dram_dout
    );

    modport slave (
        input  c_req, c_we, c_be, c_addr, c_wdat,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdat, d_last,
        output d_gnt, d_rvalid, d_rdata,
        output dram_we, dram_we_byte, dram_rd, dram_addr, dram_wdat,
        input  dram_dout
    );

endinterface

// File: rtl/dram_rsp_reg.sv
// Captures RAM read data on a granted read and returns it to the owning port one cycle later.
module dram_rsp_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_rd,
    input  logic        d_rd,
    input  logic [31:0] dram_dout,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        d_rvalid,
    output logic [31:0] d_rdata
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            c_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            c_rvalid <= c_rd;
            d_rvalid <= d_rd;
            if (c_rd) c_rdata <= dram_dout;
            if (d_rd) d_rdata <= dram_dout;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Single-port data-RAM arbiter: core priority, DMA anti-starvation and DMA burst locking.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int AW         = 32
) (
    input  logic           clk,
    input  logic           rst,
    dram_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

    state_t        state, state_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic [BW-1:0] beat_cnt, beat_n;
    logic          c_gnt, d_gnt, any_gnt;
    req_t          c_r, d_r, sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            beat_cnt   <= beat_n;
        end
    end

    // Grants are suppressed while reset is asserted so no RAM access starts then.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            unique case (state)
                ARB: begin
                    if (bus.d_req && (!bus.c_req || starve_cnt == STARVE_LIM)) d_gnt = 1'b1;
                    else if (bus.c_req)                                       c_gnt = 1'b1;
                end
                BURST: begin
                    if (bus.c_req && (beat_cnt == BURST_LIM || !bus.d_req)) c_gnt = 1'b1;
                    else if (bus.d_req)                                    d_gnt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        c_r = '{we: bus.c_we, be: bus.c_be, addr: REQ_AW'(bus.c_addr),
                wdat: bus.c_wdat, last: 1'b1};
        d_r = '{we: bus.d_we, be: bus.d_be, addr: REQ_AW'(bus.d_addr),
                wdat: bus.d_wdat, last: bus.d_last};
        sel     = d_gnt ? d_r : c_r;
        any_gnt = c_gnt | d_gnt;
    end

    always_comb begin
        state_n  = state;
        starve_n = starve_cnt;
        beat_n   = beat_cnt;

        if (d_gnt)                                      starve_n = '0;
        else if (bus.d_req && starve_cnt != STARVE_LIM) starve_n = starve_cnt + 1'b1;

        unique case (state)
            ARB: begin
                if (d_gnt && !sel.last) begin
                    state_n = BURST;
                    beat_n  = BW'(1);
                end
            end
            BURST: begin
                if (d_gnt) begin
                    if (sel.last) begin
                        state_n = ARB;
                        beat_n  = '0;
                    end else if (beat_cnt != BURST_LIM) begin
                        beat_n = beat_cnt + 1'b1;
                    end
                end else if (c_gnt && beat_cnt == BURST_LIM) begin
                    beat_n = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.c_gnt        = c_gnt;
        bus.d_gnt        = d_gnt;
        bus.dram_we      = any_gnt & sel.we;
        bus.dram_rd      = any_gnt & ~sel.we;
        bus.dram_we_byte = (any_gnt & sel.we) ? sel.be : '0;
        bus.dram_addr    = AW'(sel.addr);
        bus.dram_wdat    = sel.wdat;
    end

    dram_rsp_reg u_rsp (
        .clk       (clk),
        .rst       (rst),
        .c_rd      (c_gnt & ~bus.c_we),
        .d_rd      (d_gnt & ~bus.d_we),
        .dram_dout (bus.dram_dout),
        .c_rvalid  (bus.c_rvalid),
        .c_rdata   (bus.c_rdata),
        .d_rvalid  (bus.d_rvalid),
        .d_rdata   (bus.d_rdata)
    );

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural byte-lane RAM behind the RAM port.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vec  = 0;
    int   errs = 0;

    logic [31:0] mem [0:255];

    dram_arbiter_if #(.AW(32)) bif ();

    dram_arbiter #(
        .STARVE_MAX (8),
        .BURST_MAX  (16),
        .AW         (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    assign bif.dram_dout = mem[bif.dram_addr[9:2]];

    always @(posedge clk) begin
        if (bif.dram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bif.dram_we_byte[i]) mem[bif.dram_addr[9:2]][8*i +: 8] = bif.dram_wdat[8*i +: 8];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bif.c_req = 1'b1;
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b00) begin errs++; $display("FAIL reset_gnt: got %b want 00", {bif.c_gnt, bif.d_gnt}); end
        vec++; if ({bif.dram_we, bif.dram_rd, bif.dram_we_byte} !== 6'b0) begin errs++; $display("FAIL reset_ram_ctl: got %b want 000000", {bif.dram_we, bif.dram_rd, bif.dram_we_byte}); end
        vec++; if ({bif.c_rvalid, bif.d_rvalid} !== 2'b00) begin errs++; $display("FAIL reset_rvalid: got %b want 00", {bif.c_rvalid, bif.d_rvalid}); end
        vec++; if ({bif.c_rdata, bif.d_rdata} !== 64'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", {bif.c_rdata, bif.d_rdata}); end
        bif.c_req = 1'b0;
    endtask

    task automatic test_core_read;
        bif.c_req = 1'b1; bif.c_we = 1'b0; bif.c_addr = 32'h10;
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b10) begin errs++; $display("FAIL core_read_gnt: got %b want 10", {bif.c_gnt, bif.d_gnt}); end
        vec++; if ({bif.dram_rd, bif.dram_we} !== 2'b10) begin errs++; $display("FAIL core_read_ctl: got %b want 10", {bif.dram_rd, bif.dram_we}); end
        vec++; if (bif.dram_addr !== 32'h10) begin errs++; $display("FAIL core_read_addr: got %h want 00000010", bif.dram_addr); end
        tick;
        bif.c_req = 1'b0;
        vec++; if (bif.c_rvalid !== 1'b1) begin errs++; $display("FAIL core_read_rvalid: got %b want 1", bif.c_rvalid); end
        vec++; if (bif.c_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL core_read_data: got %h want deadbeef", bif.c_rdata); end
        tick;
        vec++; if (bif.c_rvalid !== 1'b0) begin errs++; $display("FAIL core_read_pulse: got %b want 0", bif.c_rvalid); end
        vec++; if (bif.c_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL core_read_hold: got %h want deadbeef", bif.c_rdata); end
    endtask

    task automatic test_byte_write;
        bif.c_req = 1'b1; bif.c_we = 1'b1; bif.c_be = 4'b0010;
        bif.c_addr = 32'h20; bif.c_wdat = 32'h0000AB00;
        #1;
        vec++; if ({bif.dram_we, bif.dram_rd} !== 2'b10) begin errs++; $display("FAIL bytewr_ctl: got %b want 10", {bif.dram_we, bif.dram_rd}); end
        vec++; if (bif.dram_we_byte !== 4'b0010) begin errs++; $display("FAIL bytewr_lanes: got %b want 0010", bif.dram_we_byte); end
        tick;
        vec++; if (bif.c_rvalid !== 1'b0) begin errs++; $display("FAIL bytewr_no_rvalid: got %b want 0", bif.c_rvalid); end
        bif.c_we = 1'b0; bif.c_be = 4'b0000;
        #1;
        vec++; if (bif.dram_we_byte !== 4'b0000) begin errs++; $display("FAIL read_lanes_zero: got %b want 0000", bif.dram_we_byte); end
        tick;
        bif.c_req = 1'b0;
        vec++; if (bif.c_rdata !== 32'h1122AB44) begin errs++; $display("FAIL bytewr_readback: got %h want 1122ab44", bif.c_rdata); end
    endtask

    task automatic test_starvation;
        bif.c_req = 1'b1; bif.c_we = 1'b0; bif.c_addr = 32'h10;
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h20; bif.d_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b10) begin errs++; $display("FAIL starve_core_%0d: got %b want 10", i, {bif.c_gnt, bif.d_gnt}); end
            tick;
        end
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b01) begin errs++; $display("FAIL starve_dma_gnt: got %b want 01", {bif.c_gnt, bif.d_gnt}); end
        vec++; if (bif.dram_addr !== 32'h20) begin errs++; $display("FAIL starve_dma_addr: got %h want 00000020", bif.dram_addr); end
        tick;
        bif.d_req = 1'b0;
        vec++; if (dut.starve_cnt !== 4'd0) begin errs++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); end
        vec++; if ({bif.d_rvalid, bif.d_rdata} !== {1'b1, 32'h1122AB44}) begin errs++; $display("FAIL starve_dma_data: got %b/%h want 1/1122ab44", bif.d_rvalid, bif.d_rdata); end
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b10) begin errs++; $display("FAIL starve_core_after: got %b want 10", {bif.c_gnt, bif.d_gnt}); end
        tick;
        bif.c_req = 1'b0;
    endtask

    task automatic test_dma_burst;
        bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_be = 4'hF;
        for (int b = 0; b < 4; b++) begin
            bif.d_addr = 32'h40 + 32'(4 * b);
            bif.d_wdat = 32'hA0000000 + 32'(b);
            bif.d_last = (b == 3);
            if (b == 1) begin bif.c_req = 1'b1; bif.c_we = 1'b0; bif.c_addr = 32'h10; end
            #1;
            vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b01) begin errs++; $display("FAIL burst_beat_%0d: got %b want 01", b + 1, {bif.c_gnt, bif.d_gnt}); end
            tick;
        end
        bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_be = 4'h0; bif.d_last = 1'b1;
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b10) begin errs++; $display("FAIL burst_core_after: got %b want 10", {bif.c_gnt, bif.d_gnt}); end
        tick;
        bif.c_req = 1'b0;
        vec++; if (dut.state !== ARB) begin errs++; $display("FAIL burst_state_arb: got %0d want %0d", dut.state, ARB); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (mem[16 + i] !== 32'hA0000000 + 32'(i)) begin errs++; $display("FAIL burst_mem_%0d: got %h want %h", i, mem[16 + i], 32'hA0000000 + 32'(i)); end
        end
    endtask

    task automatic test_burst_limit;
        int  b;
        int  pulses;
        logic core_slot;
        b = 0; pulses = 0;
        bif.c_we = 1'b0; bif.c_addr = 32'h10;
        bif.d_we = 1'b0; bif.d_be = 4'h0;
        for (int cyc = 0; cyc < 21; cyc++) begin
            core_slot  = (cyc == 16);
            bif.d_req  = 1'b1;
            bif.d_addr = 32'h100 + 32'(4 * b);
            bif.d_last = (b == 19);
            bif.c_req  = (cyc >= 1);
            #1;
            vec++; if ({bif.c_gnt, bif.d_gnt} !== (core_slot ? 2'b10 : 2'b01)) begin errs++; $display("FAIL limit_gnt_cyc%0d: got %b want %b", cyc, {bif.c_gnt, bif.d_gnt}, core_slot ? 2'b10 : 2'b01); end
            if (core_slot) begin
                vec++; if (bif.dram_addr !== 32'h10) begin errs++; $display("FAIL limit_core_addr: got %h want 00000010", bif.dram_addr); end
            end
            tick;
            vec++; if (bif.d_rvalid !== !core_slot) begin errs++; $display("FAIL limit_rvalid_cyc%0d: got %b want %b", cyc, bif.d_rvalid, !core_slot); end
            if (bif.d_rvalid) pulses++;
            if (!core_slot) begin
                vec++; if (bif.d_rdata !== 32'hC0DE0000 + 32'(b)) begin errs++; $display("FAIL limit_data_%0d: got %h want %h", b + 1, bif.d_rdata, 32'hC0DE0000 + 32'(b)); end
                b++;
            end
        end
        bif.d_req = 1'b0; bif.d_last = 1'b1;
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b10) begin errs++; $display("FAIL limit_core_after: got %b want 10", {bif.c_gnt, bif.d_gnt}); end
        tick;
        bif.c_req = 1'b0;
        vec++; if (pulses !== 20) begin errs++; $display("FAIL limit_pulse_count: got %0d want 20", pulses); end
    endtask

    task automatic test_reset_mid_read;
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h104; bif.d_last = 1'b1;
        #1;
        vec++; if (bif.d_gnt !== 1'b1) begin errs++; $display("FAIL rstmid_pre_gnt: got %b want 1", bif.d_gnt); end
        rst = 1'b1;
        #1;
        vec++; if ({bif.d_gnt, bif.dram_rd} !== 2'b00) begin errs++; $display("FAIL rstmid_gnt: got %b want 00", {bif.d_gnt, bif.dram_rd}); end
        tick;
        vec++; if ({bif.c_rvalid, bif.d_rvalid} !== 2'b00) begin errs++; $display("FAIL rstmid_rvalid: got %b want 00", {bif.c_rvalid, bif.d_rvalid}); end
        vec++; if ({bif.c_rdata, bif.d_rdata} !== 64'h0) begin errs++; $display("FAIL rstmid_rdata: got %h want 0", {bif.c_rdata, bif.d_rdata}); end
        bif.d_req = 1'b0;
        rst = 1'b0;
        bif.c_req = 1'b1; bif.c_we = 1'b0; bif.c_addr = 32'h10;
        #1;
        vec++; if ({bif.c_gnt, bif.d_gnt} !== 2'b10) begin errs++; $display("FAIL rstmid_core_gnt: got %b want 10", {bif.c_gnt, bif.d_gnt}); end
        tick;
        bif.c_req = 1'b0;
        vec++; if ({bif.c_rvalid, bif.c_rdata} !== {1'b1, 32'hDEADBEEF}) begin errs++; $display("FAIL rstmid_core_data: got %b/%h want 1/deadbeef", bif.c_rvalid, bif.c_rdata); end
    endtask

    initial begin
        rst = 1'b1;
        bif.c_req = 1'b0; bif.c_we = 1'b0; bif.c_be = '0; bif.c_addr = '0; bif.c_wdat = '0;
        bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_be = '0; bif.d_addr = '0; bif.d_wdat = '0;
        bif.d_last = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
        for (int i = 0; i < 20; i++) mem[64 + i] = 32'hC0DE0000 + 32'(i);

        tick;
        tick;
        test_reset;
        rst = 1'b0;
        tick;
        test_core_read;
        test_byte_write;
        test_starvation;
        test_dma_burst;
        test_burst_limit;
        test_reset_mid_read;

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
